// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding, the queued
// command record and the default APB address/data widths.
package apb_pkg;

    localparam int A_WIDTH = 8;
    localparam int D_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    typedef struct packed {
        logic               write;
        logic [A_WIDTH-1:0] addr;
        logic [D_WIDTH-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous show-ahead FIFO of apb_cmd_t records. dout always presents the
// head entry. full/empty come straight from the count register, so they never
// react combinationally to a pop in the same cycle.
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     p_clk,
    input  logic     p_rst,
    input  logic     push,
    input  logic     pop,
    input  apb_cmd_t din,
    output apb_cmd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    apb_cmd_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push_ok;
    logic            pop_ok;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge p_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: queues read/write commands from a valid/ready port, runs each
// as an APB SETUP->ACCESS transfer and returns a one-cycle response pulse.
// All APB and response outputs are registered.
// Optional feature macro: APB_TIMEOUT_EN -- bounds the ACCESS wait to
// TIMEOUT_CYCLES cycles of p_ready=0 and flags the response as timed out.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready depends only on registered FIFO occupancy. rsp_valid is a
// single-cycle pulse with no backpressure.
module apb_master_bridge #(
    parameter int A_WIDTH        = apb_pkg::A_WIDTH,
    parameter int D_WIDTH        = apb_pkg::D_WIDTH,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               p_clk,
    input  logic               p_rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [A_WIDTH-1:0] cmd_addr,
    input  logic [D_WIDTH-1:0] cmd_wdata,
    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               rsp_timeout,
    output logic               p_sel,
    output logic               p_enable,
    output logic               p_write,
    output logic [A_WIDTH-1:0] p_addr,
    output logic [D_WIDTH-1:0] wr_data,
    input  logic [D_WIDTH-1:0] rd_data,
    input  logic               p_ready,
    input  logic               p_slverr
);

    import apb_pkg::*;

    apb_mst_state_e     state_q;
    apb_mst_state_e     state_d;
    apb_cmd_t           fifo_din;
    apb_cmd_t           fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    logic               sel_d;
    logic               enable_d;
    logic               write_d;
    logic [A_WIDTH-1:0] addr_d;
    logic [D_WIDTH-1:0] wdata_d;
    logic               rsp_valid_d;
    logic [D_WIDTH-1:0] rsp_rdata_d;
    logic               rsp_err_d;
    logic               tmo_hit;

    assign fifo_din.write = cmd_write;
    assign fifo_din.addr  = cmd_addr;
    assign fifo_din.wdata = cmd_wdata;
    assign fifo_push      = cmd_valid && cmd_ready;
    assign cmd_ready      = !fifo_full;

    apb_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .p_clk (p_clk),
        .p_rst (p_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] tmo_cnt_q;
    logic [TW-1:0] tmo_cnt_d;
    logic          rsp_timeout_d;
    logic          rsp_timeout_q;

    assign rsp_timeout = rsp_timeout_q;
`else
    logic unused_tmo;

    assign unused_tmo  = (TIMEOUT_CYCLES >= 2);
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // Next-state and next-output logic; registers hold unless a transition changes them.
    always_comb begin
        state_d     = state_q;
        sel_d       = p_sel;
        enable_d    = p_enable;
        write_d     = p_write;
        addr_d      = p_addr;
        wdata_d     = wr_data;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        fifo_pop    = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        tmo_hit       = 1'b0;
        rsp_timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    write_d  = fifo_dout.write;
                    addr_d   = fifo_dout.addr;
                    wdata_d  = fifo_dout.wdata;
                    sel_d    = 1'b1;
                    enable_d = 1'b0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                enable_d = 1'b1;
                state_d  = ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ACCESS: begin
`ifdef APB_TIMEOUT_EN
                tmo_hit = !p_ready && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
                if (!p_ready) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
                if (p_ready || tmo_hit) begin
                    rsp_valid_d = 1'b1;
                    if (tmo_hit) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
`ifdef APB_TIMEOUT_EN
                        rsp_timeout_d = 1'b1;
`endif
                    end else begin
                        rsp_err_d   = p_slverr;
                        rsp_rdata_d = p_write ? '0 : rd_data;
                    end
                    if (!fifo_empty) begin
                        // Back-to-back: p_sel stays high, new SETUP phase.
                        fifo_pop = 1'b1;
                        write_d  = fifo_dout.write;
                        addr_d   = fifo_dout.addr;
                        wdata_d  = fifo_dout.wdata;
                        sel_d    = 1'b1;
                        enable_d = 1'b0;
                        state_d  = SETUP;
                    end else begin
                        sel_d    = 1'b0;
                        enable_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                sel_d    = 1'b0;
                enable_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus and discards any transfer in flight.
    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state_q   <= IDLE;
            p_sel     <= 1'b0;
            p_enable  <= 1'b0;
            p_write   <= 1'b0;
            p_addr    <= '0;
            wr_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_sel     <= sel_d;
            p_enable  <= enable_d;
            p_write   <= write_d;
            p_addr    <= addr_d;
            wr_data   <= wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    // Wait-cycle counter and timeout flag of the response.
    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: table of commands with slave
// behaviour, an APB slave model checking bus contents, and a response
// scoreboard. The timeout sequence runs only when APB_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int NEVER = 1000;

  logic          p_clk = 1'b0;
  logic          p_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          p_sel;
  logic          p_enable;
  logic          p_write;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data = '0;
  logic          p_ready = 1'b0;
  logic          p_slverr = 1'b0;

  apb_master_bridge #(
    .A_WIDTH(AW), .D_WIDTH(DW), .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .p_clk(p_clk), .p_rst(p_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write), .p_addr(p_addr),
    .wr_data(wr_data), .rd_data(rd_data), .p_ready(p_ready), .p_slverr(p_slverr)
  );

  // clock / reset
  always #5 p_clk = ~p_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] rdata;
    logic          slverr;
  } vec_t;

  vec_t          slv_q[$];
  logic [DW+1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // APB slave model: checks bus contents against the queued command and
  // answers after the command's wait count. Outside ACCESS it drives noise.
  int acc_cnt = 0;
  bit in_acc  = 0;
  always @(negedge p_clk) begin
    vec_t cur;
    if (p_rst) begin
      acc_cnt  = 0;
      in_acc   = 0;
      p_ready  = 1'b0;
      p_slverr = 1'b0;
    end else if (p_sel && p_enable) begin
      in_acc = 1;
      chk("access_has_cmd", (slv_q.size() != 0), 1);
      if (slv_q.size() != 0) begin
        cur = slv_q[0];
        chk("apb_addr", p_addr, cur.addr);
        chk("apb_write", p_write, cur.write);
        if (cur.write) chk("apb_wdata", wr_data, cur.wdata);
        if (acc_cnt >= cur.waits) begin
          p_ready  = 1'b1;
          rd_data  = cur.rdata;
          p_slverr = cur.slverr;
          void'(slv_q.pop_front());
          acc_cnt = 0;
          in_acc  = 0;
        end else begin
          p_ready  = 1'b0;
          rd_data  = DW'($urandom);
          p_slverr = 1'($urandom_range(0, 1));
          acc_cnt++;
        end
      end
    end else begin
      if (in_acc) begin
        // transfer ended without p_ready: only a timeout may do that
        chk("timeout_len", acc_cnt, TMO);
        if (slv_q.size() != 0) void'(slv_q.pop_front());
        in_acc  = 0;
        acc_cnt = 0;
      end
      p_ready  = 1'($urandom_range(0, 1));
      rd_data  = DW'($urandom);
      p_slverr = 1'($urandom_range(0, 1));
    end
  end

  // response scoreboard
  always @(negedge p_clk) begin
    logic [DW+1:0] e;
    if (!p_rst && rsp_valid) begin
      chk("rsp_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp", {rsp_timeout, rsp_err, rsp_rdata}, e);
      end
    end
  end

  // driver: called just after a rising edge; returns just after the accepting edge
  task automatic send(input vec_t v);
    int t = 0;
    logic [DW+1:0] e;
    while (!cmd_ready && t < 500) begin
      @(posedge p_clk); #1; t++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", cmd_ready, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    @(posedge p_clk); #1;
    cmd_valid = 1'b0;
    cmd_wdata = DW'($urandom);
    slv_q.push_back(v);
    if (v.waits >= NEVER) e = {1'b1, 1'b1, {DW{1'b0}}};
    else                  e = {1'b0, v.slverr, (v.write ? {DW{1'b0}} : v.rdata)};
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge p_clk); #1; t++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) begin @(posedge p_clk); #1; end
  endtask

  vec_t tbl[8];
  vec_t v;
  bit   flag;
  int   t;

  initial begin
    tbl[0] = '{1'b0, 8'h03, 8'h00, 3, 8'h5A, 1'b0};
    tbl[1] = '{1'b1, 8'h10, 8'h3C, 0, 8'h99, 1'b1};
    tbl[2] = '{1'b0, 8'h20, 8'h00, 1, 8'hC3, 1'b1};
    tbl[3] = '{1'b1, 8'hFF, 8'hFF, 2, 8'h11, 1'b0};
    for (int i = 4; i < 8; i++) begin
      tbl[i].write  = 1'($urandom_range(0, 1));
      tbl[i].addr   = AW'($urandom_range(0, 255));
      tbl[i].wdata  = DW'($urandom_range(0, 255));
      tbl[i].waits  = $urandom_range(0, 4);
      tbl[i].rdata  = DW'($urandom_range(0, 255));
      tbl[i].slverr = 1'($urandom_range(0, 1));
    end

    // reset state
    repeat (3) @(posedge p_clk);
    #1 p_rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", p_sel, 0);
    chk("rst_penable", p_enable, 0);
    chk("rst_pwrite", p_write, 0);
    chk("rst_paddr", p_addr, 0);
    chk("rst_wrdata", wr_data, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);

    // zero-wait write: latency and phase sequence
    v = '{1'b1, 8'h03, 8'hA5, 0, 8'h77, 1'b0};
    send(v);
    chk("lat_n_psel", p_sel, 0);
    @(posedge p_clk); #1;
    chk("lat_setup", {p_sel, p_enable}, 2'b10);
    chk("lat_setup_addr", p_addr, 8'h03);
    chk("lat_setup_data", {p_write, wr_data}, {1'b1, 8'hA5});
    @(posedge p_clk); #1;
    chk("lat_access", {p_sel, p_enable}, 2'b11);
    chk("lat_access_rsp", rsp_valid, 0);
    @(posedge p_clk); #1;
    chk("lat_rsp_valid", rsp_valid, 1);
    chk("lat_idle_bus", {p_sel, p_enable}, 2'b00);
    chk("lat_idle_keep", {p_addr, wr_data}, {8'h03, 8'hA5});
    @(posedge p_clk); #1;
    chk("lat_rsp_pulse", rsp_valid, 0);
    drain();

    // table of commands, applied one after another
    for (int i = 0; i < 8; i++) send(tbl[i]);
    drain();

    // back-to-back: first transfer stalls so the FIFO fills
    v = '{1'b1, 8'h40, 8'h01, 8, 8'h00, 1'b0};
    send(v);
    for (int i = 1; i < 5; i++) begin
      v = '{1'(i & 1), AW'(8'h40 + i), DW'(8'h10 * i), i & 1, DW'(8'hE0 + i), 1'b0};
      send(v);
    end
    chk("b2b_full_ready", cmd_ready, 0);
    flag = 0;
    t = 0;
    while (exp_q.size() > 1 && t < 500) begin
      if (!p_sel) flag = 1;
      @(posedge p_clk); #1; t++;
    end
    chk("b2b_psel_held", flag, 0);
    drain();
    chk("b2b_ready_back", cmd_ready, 1);

`ifdef APB_TIMEOUT_EN
    // timeout, then a normal command proceeds
    v = '{1'b0, 8'h55, 8'h00, NEVER, 8'hAB, 1'b0};
    send(v);
    v = '{1'b0, 8'h56, 8'h00, 0, 8'h6D, 1'b0};
    send(v);
    drain();
`endif

    // reset during ACCESS with two commands queued
    v = '{1'b1, 8'h70, 8'h5F, NEVER, 8'h00, 1'b0};
    send(v);
    v = '{1'b1, 8'h71, 8'h60, 0, 8'h00, 1'b0};
    send(v);
    v = '{1'b0, 8'h72, 8'h00, 0, 8'h33, 1'b0};
    send(v);
    t = 0;
    while (!p_enable && t < 50) begin
      @(posedge p_clk); #1; t++;
    end
    chk("rst_mid_in_access", p_enable, 1);
    p_rst = 1'b1;
    exp_q.delete();
    slv_q.delete();
    @(posedge p_clk); #1;
    p_rst = 1'b0;
    chk("rst_mid_bus", {p_sel, p_enable}, 2'b00);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_rsp", rsp_valid, 0);
    flag = 0;
    for (int i = 0; i < 6; i++) begin
      if (p_sel || rsp_valid) flag = 1;
      @(posedge p_clk); #1;
    end
    chk("rst_mid_fifo_empty", flag, 0);

    // normal operation after reset
    v = '{1'b0, 8'h0C, 8'h00, 2, 8'h4E, 1'b0};
    send(v);
    drain();

    chk("final_slv_q", slv_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
